// File: rtl/adq_pkg.sv
// adq_pkg: shared types, mode constants and wrap helper for addr_data_queue.
package adq_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DUMP} dump_state_e;
  localparam int MODE_FIFO = 0;
  localparam int MODE_LIFO = 1;
  function automatic int adq_wrap_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/adq_storage.sv
// adq_storage: register array with one write port and combinational pop/dump read ports.
module adq_storage #(
  parameter int W     = 64,
  parameter int DEPTH = 16,
  parameter int PW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [PW-1:0] pop_raddr,
  output logic [W-1:0]  pop_rdata,
  input  logic [PW-1:0] dump_raddr,
  output logic [W-1:0]  dump_rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign pop_rdata  = mem[pop_raddr];
  assign dump_rdata = mem[dump_raddr];
endmodule

// File: rtl/addr_data_queue.sv
// addr_data_queue: FIFO/LIFO queue of {addr,data} pairs with a non-destructive dump engine.
// Define ADQ_ERR_FLAGS_EN to add sticky ovf_err/udf_err outputs.
module addr_data_queue import adq_pkg::*; #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int MODE  = 0,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [AW-1:0] pop_addr,
  output logic [DW-1:0] pop_data,
  input  logic          dump_req,
  output logic          dump_busy,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          dump_last,
  output logic [CW-1:0] count,
  output logic          empty,
`ifdef ADQ_ERR_FLAGS_EN
  output logic          ovf_err,
  output logic          udf_err,
`endif
  output logic          full
);
  logic [PW-1:0] wr_ptr, rd_ptr, dump_base, base, waddr, pop_raddr, dump_raddr;
  logic [CW-1:0] dump_len, idx, k, len;
  logic [AW+DW-1:0] pop_word, dump_word;
  logic push, pop, enter, beat_en;
  dump_state_e state, state_nx;
  int sum;

  assign full       = count == CW'(DEPTH);
  assign empty      = count == '0;
  assign push_ready = !full;
  assign dump_busy  = state != IDLE;
  assign pop_valid  = !empty && !dump_busy;
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  assign {pop_addr, pop_data} = pop_word;
  // LIFO push+pop replaces the current top in place
  assign waddr     = (MODE == MODE_LIFO) ? PW'(pop ? count - 1'b1 : count) : wr_ptr;
  assign pop_raddr = (MODE == MODE_LIFO) ? PW'(count - 1'b1) : rd_ptr;

  adq_storage #(.W(AW + DW), .DEPTH(DEPTH), .PW(PW)) u_storage (
    .clk        (clk),
    .we         (push),
    .waddr      (waddr),
    .wdata      ({push_addr, push_data}),
    .pop_raddr  (pop_raddr),
    .pop_rdata  (pop_word),
    .dump_raddr (dump_raddr),
    .dump_rdata (dump_word)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      if (push && MODE == MODE_FIFO) wr_ptr <= PW'(adq_wrap_inc(int'(wr_ptr), DEPTH));
      if (pop && MODE == MODE_FIFO) rd_ptr <= PW'(adq_wrap_inc(int'(rd_ptr), DEPTH));
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;

  assign enter = ((state == IDLE && dump_req) || state == WAIT) && count != '0;

  always_comb begin
    state_nx = enter ? DUMP :
               (state == IDLE && dump_req) ? WAIT :
               (state == DUMP && dump_last) ? IDLE : state;
  end

  // Beat 0 is issued on the entry edge using the live count/rd_ptr snapshot
  always_comb begin
    beat_en    = enter || (state == DUMP && !dump_last);
    k          = enter ? '0 : idx;
    len        = enter ? count : dump_len;
    base       = enter ? rd_ptr : dump_base;
    sum        = int'(base) + int'(k);
    dump_raddr = (MODE == MODE_LIFO) ? PW'(len - k - 1'b1) : PW'(sum >= DEPTH ? sum - DEPTH : sum);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {dump_valid, dump_last, dump_addr, dump_data, dump_len, idx, dump_base} <= '0;
    end else begin
      dump_valid <= beat_en;
      dump_last  <= beat_en && (k == len - 1'b1);
      idx        <= beat_en ? k + 1'b1 : '0;
      if (beat_en) {dump_addr, dump_data} <= dump_word;
      if (enter) begin
        dump_len  <= count;
        dump_base <= rd_ptr;
      end
    end

`ifdef ADQ_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (push_valid && full) ovf_err <= 1'b1;
      if (pop_ready && !pop_valid) udf_err <= 1'b1;
    end
`endif
endmodule
